// File: rtl/pcu_pkg.sv
// Shared PC-control definitions: jump_code encoding seen by jump_ctrl and the PC.
package pcu_pkg;

  localparam int JUMP_CODE_W = 5;

  typedef enum logic [JUMP_CODE_W-1:0] {
    JC_RESET   = 5'd0,
    JC_JUMP    = 5'd1,
    JC_RET     = 5'd2,
    JC_DEFAULT = 5'd3
  } jump_code_e;

endpackage

// File: rtl/jump_ctrl_ret_stack.sv
// Return-address LIFO. Push when full and pop when empty are silently ignored;
// error policy belongs to the caller. top_o reads 0 while empty.
module ret_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 push_data_i,
  output logic [W-1:0]                 top_o,
  output logic [$clog2(DEPTH+1)-1:0]   depth_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] ONE = DW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic [AW-1:0] wr_idx, top_idx;

  assign full_o  = (depth_q == DW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;
  assign wr_idx  = depth_q[AW-1:0];
  assign top_idx = AW'(depth_q - ONE);
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o)       depth_d = depth_q + ONE;
    else if (pop_i && !empty_o)  depth_d = depth_q - ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // Contents need no reset: depth_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/jump_ctrl.sv
// Call/jump/return decode feeding the PC, plus the return-address stack.
// Optional macro PCU_STACK_TRAP_EN redirects overflow/underflow to TRAP_ADDR.
module jump_ctrl
  import pcu_pkg::*;
#(
  parameter int INSTR_ADDR_SIZE = 8,
  parameter int STACK_DEPTH     = 8,
  parameter logic [INSTR_ADDR_SIZE-1:0] TRAP_ADDR = '0
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               is_call,
  input  logic                               is_jump,
  input  logic                               is_ret,
  input  logic [INSTR_ADDR_SIZE-1:0]         target,
  input  logic [INSTR_ADDR_SIZE-1:0]         instruction_address,
  output logic [JUMP_CODE_W-1:0]             jump_code,
  output logic [INSTR_ADDR_SIZE-1:0]         jump_address,
  output logic [INSTR_ADDR_SIZE-1:0]         return_address,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_err
);

`ifdef PCU_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  jump_code_e                 code;
  logic                       push, pop, err_set;
  logic                       full, empty;
  logic                       stack_err_q, stack_err_d;
  logic [INSTR_ADDR_SIZE-1:0] ret_point;

  assign ret_point = instruction_address + INSTR_ADDR_SIZE'(1);

  ret_stack #(
    .W     (INSTR_ADDR_SIZE),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (ret_point),
    .top_o       (return_address),
    .depth_o     (depth),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Priority RESET > call > jump > ret; stack faults redirect only in trap builds.
  always_comb begin
    code         = JC_DEFAULT;
    jump_address = target;
    push         = 1'b0;
    pop          = 1'b0;
    err_set      = 1'b0;
    if (RESET) begin
      code = JC_RESET;
    end else if (is_call) begin
      code = JC_JUMP;
      if (full) begin
        err_set = 1'b1;
        if (TRAP_EN) jump_address = TRAP_ADDR;
      end else begin
        push = 1'b1;
      end
    end else if (is_jump) begin
      code = JC_JUMP;
    end else if (is_ret) begin
      if (empty) begin
        err_set = 1'b1;
        if (TRAP_EN) begin
          code         = JC_JUMP;
          jump_address = TRAP_ADDR;
        end else begin
          code = JC_RET;
        end
      end else begin
        code = JC_RET;
        pop  = 1'b1;
      end
    end
  end

  assign jump_code   = code;
  assign stack_err_d = stack_err_q | err_set;
  assign stack_err   = stack_err_q;

  always_ff @(posedge CLK) begin
    if (RESET) stack_err_q <= 1'b0;
    else       stack_err_q <= stack_err_d;
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Randomized and directed bench for jump_ctrl against a queue-based stack model.
module tb_jump_ctrl;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam logic [W-1:0] TRAP = 8'hF0;
`ifdef PCU_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         is_call = 1'b0, is_jump = 1'b0, is_ret = 1'b0;
  logic [W-1:0] target = '0, instruction_address = '0;
  logic [4:0]   jump_code;
  logic [W-1:0] jump_address, return_address;
  logic [3:0]   depth;
  logic         stack_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  bit           err_m = 1'b0;

  always #5 CLK = ~CLK;

  jump_ctrl #(
    .INSTR_ADDR_SIZE (W),
    .STACK_DEPTH     (DEPTH),
    .TRAP_ADDR       (TRAP)
  ) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .is_call             (is_call),
    .is_jump             (is_jump),
    .is_ret              (is_ret),
    .target              (target),
    .instruction_address (instruction_address),
    .jump_code           (jump_code),
    .jump_address        (jump_address),
    .return_address      (return_address),
    .depth               (depth),
    .stack_err           (stack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One instruction: drive at negedge, check combinational outputs, then advance the model.
  task automatic step(input bit rst, input bit call, input bit jmp, input bit ret,
                      input logic [W-1:0] tgt, input logic [W-1:0] pc);
    logic [4:0]   e_jc;
    logic [W-1:0] e_ja, e_ra, nxt;
    bit           do_push, do_pop, set_err;
    @(negedge CLK);
    RESET = rst; is_call = call; is_jump = jmp; is_ret = ret;
    target = tgt; instruction_address = pc;
    #1;
    e_ja = tgt;
    e_ra = (exp_q.size() != 0) ? exp_q[$] : '0;
    do_push = 0; do_pop = 0; set_err = 0;
    if (rst) e_jc = 5'd0;
    else if (call) begin
      e_jc = 5'd1;
      if (exp_q.size() == DEPTH) begin
        set_err = 1;
        if (TRAP_EN) e_ja = TRAP;
      end else do_push = 1;
    end else if (jmp) e_jc = 5'd1;
    else if (ret) begin
      if (exp_q.size() == 0) begin
        set_err = 1;
        e_jc = TRAP_EN ? 5'd1 : 5'd2;
        if (TRAP_EN) e_ja = TRAP;
      end else begin
        e_jc = 5'd2;
        do_pop = 1;
      end
    end else e_jc = 5'd3;
    check("jump_code",      32'(jump_code),      32'(e_jc));
    check("jump_address",   32'(jump_address),   32'(e_ja));
    check("return_address", 32'(return_address), 32'(e_ra));
    check("depth",          32'(depth),          32'(exp_q.size()));
    check("stack_err",      32'(stack_err),      32'(err_m));
    @(posedge CLK);
    if (rst) begin
      exp_q.delete();
      err_m = 1'b0;
    end else begin
      nxt = pc + 8'd1;
      if (do_push) exp_q.push_back(nxt);
      if (do_pop)  void'(exp_q.pop_back());
      if (set_err) err_m = 1'b1;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    // Reset held with is_call asserted.
    step(1, 1, 0, 0, 8'h40, 8'h10);
    step(1, 1, 0, 0, 8'h40, 8'h10);
    idle();
    // Single call/return.
    step(0, 1, 0, 0, 8'h40, 8'h10);
    step(0, 0, 0, 1, 8'h00, 8'h40);
    idle();
    // Nested calls.
    step(0, 1, 0, 0, 8'h20, 8'h05);
    step(0, 1, 0, 0, 8'h30, 8'h20);
    step(0, 1, 0, 0, 8'h50, 8'h30);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h00, 8'h60);
    idle();
    // Overflow: nine calls.
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 8'h80 + 8'(i), 8'(i));
    idle();
    // Underflow after reset.
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 0, 1, 8'h12, 8'h34);
    idle();
    // Wrap, simultaneous call+ret, plain jump, reset at depth 3.
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(0, 1, 0, 0, 8'h07, 8'hFF);
    step(0, 1, 0, 1, 8'h09, 8'h07);
    step(0, 0, 1, 0, 8'hAA, 8'h08);
    step(0, 0, 0, 1, 8'h00, 8'hAA);
    step(0, 0, 0, 1, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h10, 8'h20 + 8'(i));
    step(1, 0, 0, 0, 8'h00, 8'h00);
    idle();
    // Random traffic, biased toward calls and returns so both stack limits get hit.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      step(sel < 2, (sel >= 2 && sel < 45), (sel >= 45 && sel < 55) || ($urandom_range(0, 9) == 0),
           (sel >= 55 && sel < 95) || ($urandom_range(0, 9) == 0),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Control stage directly upstream of the program counter.
- Turns decoded call/jump/return flags into the PC's 5-bit jump_code, jump_address and return_address.
- Owns a hardware return-address stack (LIFO) that holds the return point for nested subroutine calls.
- The PC registers these outputs on the same CLK edge. The control path is combinational from inputs and stack state; all stack state is registered.

Parameters:
- INSTR_ADDR_SIZE, 8: width of instruction addresses.
- STACK_DEPTH, 8: number of return-address entries (>=2).
- TRAP_ADDR, 0: trap vector. Used only when the optional feature is compiled in.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- is_call  in  1  current instruction is a CALL.
- is_jump  in  1  current instruction is an unconditional JUMP.
- is_ret  in  1  current instruction is a RET.
- target  in  INSTR_ADDR_SIZE  jump/call destination from decode.
- instruction_address  in  INSTR_ADDR_SIZE  current PC value (fed back from the PC).
- jump_code  out  5  to PC: 0=RESET, 1=JUMP, 2=RET, 3=DEFAULT (increment).
- jump_address  out  INSTR_ADDR_SIZE  to PC: destination for JUMP.
- return_address  out  INSTR_ADDR_SIZE  to PC: top of stack, or 0 when the stack is empty.
- depth  out  $clog2(STACK_DEPTH+1)  current stack occupancy.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high, named RESET.
- While RESET=1:
  - jump_code=0 combinationally, so the PC clears on the same edge.
  - On that edge, depth becomes 0 and stack_err becomes 0.
  - Stack contents are don't-care.
- Reset arriving mid-call-chain discards all entries. There is no partial recovery.
- Decode priority when several flags are high (illegal, but defined): RESET > is_call > is_jump > is_ret.
- CALL:
  - jump_code=1, jump_address=target.
  - On the edge, push (instruction_address+1) mod 2^INSTR_ADDR_SIZE and increment depth.
  - PC = 2^W-1 therefore pushes 0.
- JUMP: jump_code=1, jump_address=target. Stack unchanged.
- RET:
  - jump_code=2.
  - return_address = entry at depth-1.
  - On the edge, pop and decrement depth.
- No flag: jump_code=3. Stack unchanged.
- jump_address equals target in all cases except a trap (see Optional Feature).
- return_address always presents the top of stack; it is 0 when depth=0.
- Overflow (CALL with depth=STACK_DEPTH): the jump is still taken, the push is dropped, depth is held and stack_err is set.
- Underflow (RET with depth=0): jump_code=2 with return_address=0, depth stays 0, stack_err is set.
- stack_err clears only on RESET.
- No same-cycle push and pop is possible, because only one instruction is decoded per cycle.
- Latency: zero cycles, control to PC. Stack update takes effect on the next cycle.

Optional Feature:
- Macro: PCU_STACK_TRAP_EN.
- Defined: on overflow or underflow, jump_code=1 and jump_address=TRAP_ADDR. The stack is not modified and stack_err is set.
- Undefined: overflow and underflow behave exactly as described in Behaviour. TRAP_ADDR is ignored.

Decomposition:
- Package pcu_pkg holds:
  - the 5-bit jump_code enum type (RESET=0, JUMP=1, RET=2, DEFAULT=3);
  - a JUMP_CODE_W=5 constant.
- jump_ctrl and the PC both import pcu_pkg.
- One natural sub-module: ret_stack.
  - Parameterised LIFO with push, pop, push_data, top, depth, full and empty.
  - Synchronous reset.
  - Push on full and pop on empty are ignored inside it; error policy stays in jump_ctrl.

Test Plan:
1. RESET=1 for 2 cycles with is_call=1 -> jump_code=0 each cycle, depth=0, stack_err=0 after release.
2. PC=0x10, is_call, target=0x40 -> jump_code=1, jump_address=0x40, next cycle depth=1, return_address=0x11. Then is_ret -> jump_code=2, return_address=0x11, next cycle depth=0.
3. Three nested calls from PCs 0x05, 0x20, 0x30, then three RETs -> return_address 0x31, 0x21, 0x06 in order, ending at depth=0.
4. STACK_DEPTH=8: nine calls -> ninth jump taken, depth stays 8, stack_err=1. With PCU_STACK_TRAP_EN and TRAP_ADDR=0xF0, the ninth call instead gives jump_address=0xF0.
5. RET at depth=0 -> jump_code=2, return_address=0, stack_err=1, depth=0. With the trap macro -> jump_code=1, jump_address=TRAP_ADDR.
6. Further cases:
   - PC=0xFF, is_call -> pushed value 0x00 (wrap).
   - is_call and is_ret both high -> treated as a CALL.
   - RESET at depth=3 -> depth=0 on the next cycle.
